// File: rtl/and_gate.sv
// and_gate: registered bitwise AND of two operands behind a valid/ready
// handshake, with results held in a 2-entry FIFO.
//   - Accept when in_valid & in_ready at a rising edge; the stored result is a & b.
//   - One cycle of latency and no bypass. in_ready is a register, so it has no
//     combinational path from out_ready.
//   - While the FIFO is empty, y and y_all are forced to zero.
//   - Optional feature, enabled by defining the macro AND_GATE_HIT_COUNT_EN:
//     the hit_count output, a saturating count of accepted all-ones results.
module and_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             y_all
`ifdef AND_GATE_HIT_COUNT_EN
    ,
    output logic [CNT_W-1:0] hit_count
`endif
);

    // Reject out-of-range configurations at elaboration time.
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("and_gate: WIDTH must lie in 1..64");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("and_gate: CNT_W must be at least 1");
    end

    // True when every bit of v is set.
    function automatic logic all_ones(input logic [WIDTH-1:0] v);
        return &v;
    endfunction

`ifdef AND_GATE_HIT_COUNT_EN
    // Increment that holds at the maximum code instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c) begin
            return c;
        end
        return c + CNT_W'(1);
    endfunction
`endif

    // ---- stage p0: operand combine and handshake decode ----
    logic [WIDTH-1:0] res_p0;
    logic             vld_p0;   // a push happens at the coming edge
    logic             pop_p0;   // the head is consumed at the coming edge

    // ---- stage p1: FIFO storage and control state ----
    logic [WIDTH-1:0] ent_p1 [0:1];
    logic             wr_ptr_p1;
    logic             rd_ptr_p1;
    logic [1:0]       cnt_p1;
    logic [1:0]       cnt_nxt;
    logic             in_ready_p1;

    assign res_p0 = a & b;

    // in_ready is the registered "fewer than two entries" flag. When the FIFO
    // is full it blocks a push even if a pop happens in the same cycle; the
    // freed slot is offered from the next cycle.
    assign vld_p0 = in_valid & in_ready_p1;
    assign pop_p0 = out_valid & out_ready;

    // Next occupancy: push and pop in the same cycle leave the count unchanged.
    always_comb begin
        cnt_nxt = cnt_p1;
        unique case ({vld_p0, pop_p0})
            2'b10:   cnt_nxt = cnt_p1 + 2'd1;
            2'b01:   cnt_nxt = cnt_p1 - 2'd1;
            default: cnt_nxt = cnt_p1;
        endcase
    end

    // Occupancy and ready flag. Reset clears the queue at once and keeps
    // in_ready low until the first edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p1      <= 2'd0;
            in_ready_p1 <= 1'b0;
        end else begin
            cnt_p1      <= cnt_nxt;
            in_ready_p1 <= (cnt_nxt != 2'd2);
        end
    end

    // Write and read pointers. Each one toggles on its own handshake, so a
    // simultaneous push and pop on one entry moves the head onto the new result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_p1 <= 1'b0;
            rd_ptr_p1 <= 1'b0;
        end else begin
            if (vld_p0) begin
                wr_ptr_p1 <= ~wr_ptr_p1;
            end
            if (pop_p0) begin
                rd_ptr_p1 <= ~rd_ptr_p1;
            end
        end
    end

    // Result storage. It has no reset because the outputs are masked by
    // out_valid, and a slot is written only by a push.
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            ent_p1[wr_ptr_p1] <= res_p0;
        end
    end

`ifdef AND_GATE_HIT_COUNT_EN
    logic [CNT_W-1:0] hit_cnt_p1;

    // Count accepted results that are all ones, saturating at the top code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_p1 <= '0;
        end else if (vld_p0 && all_ones(res_p0)) begin
            hit_cnt_p1 <= sat_inc(hit_cnt_p1);
        end
    end

    assign hit_count = hit_cnt_p1;
`endif

    // ---- output: head of queue, zeroed when empty ----
    assign in_ready  = in_ready_p1;
    assign out_valid = (cnt_p1 != 2'd0);
    assign y         = out_valid ? ent_p1[rd_ptr_p1] : '0;
    assign y_all     = out_valid & all_ones(y);

endmodule

// File: tb/tb_and_gate.sv
// Directed bench for and_gate: a 1-bit streaming instance, an 8-bit
// backpressure/reset instance and, when AND_GATE_HIT_COUNT_EN is defined,
// a CNT_W=2 instance for the saturating hit counter.
module tb_and_gate;

    logic       clk;
    logic       rst;

    logic [0:0] a1, b1, y1;
    logic       iv1, ir1, ov1, or1, ya1;

    logic [7:0] a8, b8, y8;
    logic       iv8, ir8, ov8, or8, ya8;

    int passes;
    int total;

    and_gate #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(iv1), .in_ready(ir1),
        .y(y1), .out_valid(ov1), .out_ready(or1), .y_all(ya1)
`ifdef AND_GATE_HIT_COUNT_EN
        , .hit_count()
`endif
    );

    and_gate #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(iv8), .in_ready(ir8),
        .y(y8), .out_valid(ov8), .out_ready(or8), .y_all(ya8)
`ifdef AND_GATE_HIT_COUNT_EN
        , .hit_count()
`endif
    );

`ifdef AND_GATE_HIT_COUNT_EN
    logic [7:0] a2, b2, y2;
    logic       iv2, ir2, ov2, or2, ya2;
    logic [1:0] hc2;

    and_gate #(.WIDTH(8), .CNT_W(2)) u_hc (
        .clk(clk), .rst(rst), .a(a2), .b(b2), .in_valid(iv2), .in_ready(ir2),
        .y(y2), .out_valid(ov2), .out_ready(or2), .y_all(ya2), .hit_count(hc2)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        passes = 0;
        total  = 0;
        rst = 1'b1;
        a1 = '0; b1 = '0; iv1 = 1'b0; or1 = 1'b0;
        a8 = '0; b8 = '0; iv8 = 1'b0; or8 = 1'b0;
`ifdef AND_GATE_HIT_COUNT_EN
        a2 = '0; b2 = '0; iv2 = 1'b0; or2 = 1'b1;
`endif

        // Reset state
        tick();
        tick();
        check("rst_ov8", ov8, 0);
        check("rst_y8", y8, 0);
        check("rst_yall8", ya8, 0);
        check("rst_ir8", ir8, 0);
        check("rst_ir1", ir1, 0);
        check("rst_ov1", ov1, 0);
`ifdef AND_GATE_HIT_COUNT_EN
        check("rst_hc", hc2, 0);
`endif
        rst = 1'b0;
        #1;
        check("rel_ir8_before_edge", ir8, 0);
        tick();
        check("rel_ir8_after_edge", ir8, 1);
        check("rel_ir1_after_edge", ir1, 1);

        // 1-bit streaming truth table, consumer always ready
        or1 = 1'b1; iv1 = 1'b1;
        a1 = 1'b0; b1 = 1'b0; tick();
        check("w1_00_ov", ov1, 1); check("w1_00_y", y1, 0); check("w1_00_yall", ya1, 0);
        a1 = 1'b1; b1 = 1'b0; tick();
        check("w1_10_y", y1, 0); check("w1_10_yall", ya1, 0); check("w1_10_ir", ir1, 1);
        a1 = 1'b0; b1 = 1'b1; tick();
        check("w1_01_y", y1, 0); check("w1_01_yall", ya1, 0);
        a1 = 1'b1; b1 = 1'b1; tick();
        check("w1_11_ov", ov1, 1); check("w1_11_y", y1, 1); check("w1_11_yall", ya1, 1);
        iv1 = 1'b0; tick();
        check("w1_drain_ov", ov1, 0); check("w1_drain_y", y1, 0); check("w1_drain_yall", ya1, 0);

        // 8-bit fill with consumer stalled
        or8 = 1'b0; iv8 = 1'b1;
        a8 = 8'hA5; b8 = 8'hFF; tick();
        check("fill1_ov", ov8, 1); check("fill1_y", y8, 8'hA5); check("fill1_ir", ir8, 1);
        a8 = 8'h3C; b8 = 8'h0F; tick();
        check("fill2_ir", ir8, 0); check("fill2_y", y8, 8'hA5);
        a8 = 8'hFF; b8 = 8'hFF; tick();
        check("full_ir", ir8, 0); check("full_y_held", y8, 8'hA5); check("full_yall", ya8, 0);
        or8 = 1'b1; tick();
        check("full_pop_ir", ir8, 1); check("full_pop_y", y8, 8'h0C);
        iv8 = 1'b0; tick();
        check("drain_ov", ov8, 0); check("drain_y", y8, 0); check("drain_ir", ir8, 1);

        // One entry queued, push and pop together
        or8 = 1'b0; iv8 = 1'b1; a8 = 8'h12; b8 = 8'hF0; tick();
        check("pp_head0", y8, 8'h10);
        or8 = 1'b1; a8 = 8'hF0; b8 = 8'h3C; tick();
        check("pp_head1", y8, 8'h30); check("pp_ov", ov8, 1); check("pp_ir", ir8, 1);
        iv8 = 1'b0; tick();
        check("pp_count1_ov", ov8, 0);

        // Full result on y_all
        or8 = 1'b0; iv8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; tick();
        check("w8_yall_ff", ya8, 1);
        a8 = 8'h55; b8 = 8'hFF; tick();
        iv8 = 1'b0;
        check("two_q_ir", ir8, 0); check("two_q_ov", ov8, 1); check("two_q_y", y8, 8'hFF);

        // Asynchronous reset with two entries queued
        #2;
        rst = 1'b1;
        #1;
        check("arst_ov", ov8, 0); check("arst_y", y8, 0); check("arst_ir", ir8, 0); check("arst_yall", ya8, 0);
        tick();
        rst = 1'b0;
        tick();
        check("arst_rel_ir", ir8, 1); check("arst_rel_ov", ov8, 0);

`ifdef AND_GATE_HIT_COUNT_EN
        // Saturating hit counter, CNT_W=2
        iv2 = 1'b1; a2 = 8'hFF; b2 = 8'hFF;
        tick(); check("hc_1", hc2, 1);
        tick(); check("hc_2", hc2, 2);
        tick(); check("hc_3", hc2, 3);
        tick(); check("hc_sat4", hc2, 3);
        tick(); check("hc_sat5", hc2, 3);
        iv2 = 1'b0; tick();
        rst = 1'b1; #1;
        check("hc_rst", hc2, 0);
        rst = 1'b0;
        tick();
        iv2 = 1'b1; a2 = 8'h0F; b2 = 8'hFF;
        tick(); check("hc_not_ones", hc2, 0);
        iv2 = 1'b0;
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
